// File: rtl/object_scheduler_if.sv
// Object table read port and drawer start/done handshake seen by the scheduler.
interface object_scheduler_if;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] table_addr;
  logic [DATA_W-1:0] table_data;
  logic [ADDR_W-1:0] obj_addr;
  logic [DATA_W-1:0] obj_Y_X;
  logic              obj_start;
  logic              obj_done;
  logic              obj_abort;

  // Scheduler side: drives the table address and the drawer command.
  modport master (
    output table_addr, obj_addr, obj_Y_X, obj_start, obj_abort,
    input  table_data, obj_done
  );

  // Table RAM plus drawer side.
  modport slave (
    input  table_addr, obj_addr, obj_Y_X, obj_start, obj_abort,
    output table_data, obj_done
  );
endinterface

// File: rtl/object_scheduler.sv
// Per-frame sprite object sequencer: walks the object table, launches active
// slots on the drawer, draws the player slot last and aborts hung draws.
module object_scheduler #(
  parameter int unsigned FIRST_SLOT  = 2,
  parameter int unsigned LAST_SLOT   = 42,
  parameter int unsigned PLAYER_SLOT = 32,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  object_scheduler_if.master   bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_overrun,
  output logic                 timeout_err
);
  localparam int unsigned SLOT_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WD_W   = 12;

  // First visited slot; the player slot is never part of the ascending sweep.
  localparam int unsigned START_I = (FIRST_SLOT != PLAYER_SLOT) ? FIRST_SLOT :
                                    ((FIRST_SLOT + 1 > LAST_SLOT) ? PLAYER_SLOT : FIRST_SLOT + 1);

  localparam logic [SLOT_W-1:0] START_SLOT = SLOT_W'(START_I);
  localparam logic [SLOT_W-1:0] LAST       = SLOT_W'(LAST_SLOT);
  localparam logic [SLOT_W-1:0] PLAYER     = SLOT_W'(PLAYER_SLOT);
  localparam logic [WD_W-1:0]   WD_LIMIT   = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ, S_LAUNCH, S_DRAW, S_ADVANCE, S_FINISH
  } state_t;

  state_t              state, state_next;
  logic [SLOT_W-1:0]   slot, slot_next;
  logic [WD_W-1:0]     watchdog, watchdog_next;
  logic [SLOT_W-1:0]   obj_addr_q, obj_addr_next;
  logic [DATA_W-1:0]   obj_yx_q, obj_yx_next;
  logic                obj_start_q, obj_start_next;
  logic                busy_next, frame_done_next;
  logic                overrun_next, timeout_next;
  logic                abort_c;

  // Slot following s in visit order: ascending, skipping the player, player last.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    logic [SLOT_W-1:0] n;
    n = s + 1'b1;
    if (n == PLAYER) n = n + 1'b1;
    if (s == LAST || n > LAST) n = PLAYER;
    return n;
  endfunction

  assign bus.table_addr = slot;
  assign bus.obj_addr   = obj_addr_q;
  assign bus.obj_Y_X    = obj_yx_q;
  assign bus.obj_start  = obj_start_q;
  assign bus.obj_abort  = abort_c;

  // Next-state, datapath and flag updates.
  always_comb begin
    state_next      = state;
    slot_next       = slot;
    watchdog_next   = watchdog;
    obj_addr_next   = obj_addr_q;
    obj_yx_next     = obj_yx_q;
    busy_next       = busy;
    abort_c         = 1'b0;
    timeout_next    = timeout_err;
    overrun_next    = frame_overrun | (frame_start & (state != S_IDLE));

    case (state)
      S_IDLE: begin
        if (frame_start) begin
          slot_next  = START_SLOT;
          busy_next  = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_READ;
      S_READ: begin
        obj_yx_next   = bus.table_data;
        obj_addr_next = slot;
        state_next    = bus.table_data[DATA_W-1] ? S_LAUNCH : S_ADVANCE;
      end
      S_LAUNCH: begin
        watchdog_next = '0;
        state_next    = S_DRAW;
      end
      S_DRAW: begin
        if (bus.obj_done) begin
          state_next = S_ADVANCE;
        end else if (watchdog == WD_LIMIT) begin
          abort_c      = 1'b1;
          timeout_next = 1'b1;
          state_next   = S_ADVANCE;
        end else begin
          watchdog_next = watchdog + 1'b1;
        end
      end
      S_ADVANCE: begin
        if (slot == PLAYER) begin
          state_next = S_FINISH;
        end else begin
          slot_next  = next_slot(slot);
          state_next = S_FETCH;
        end
      end
      S_FINISH: begin
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    obj_start_next  = (state_next == S_LAUNCH);
    frame_done_next = (state_next == S_FINISH);
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      slot          <= '0;
      watchdog      <= '0;
      obj_addr_q    <= '0;
      obj_yx_q      <= '0;
      obj_start_q   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_next;
      slot          <= slot_next;
      watchdog      <= watchdog_next;
      obj_addr_q    <= obj_addr_next;
      obj_yx_q      <= obj_yx_next;
      obj_start_q   <= obj_start_next;
      busy          <= busy_next;
      frame_done    <= frame_done_next;
      frame_overrun <= overrun_next;
      timeout_err   <= timeout_next;
    end
  end
endmodule

// File: tb/tb_object_scheduler.sv
// Bench for object_scheduler: table RAM and drawer models, a frame-level
// timeline model and a per-cycle compare process.
module tb_object_scheduler;
  localparam int FIRST  = 2;
  localparam int LAST   = 42;
  localparam int PLAYER = 32;
  localparam int TMO    = 4095;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic busy, frame_done, frame_overrun, timeout_err;

  object_scheduler_if bus ();

  object_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    int          en;
    int          slot;
    logic [31:0] yx;
    bit          abort;
  } draw_t;

  logic [31:0] mem [64];
  int          delay [64];
  int          cyc = 0;
  int          pend = -1;
  int          errors = 0;
  int          checks = 0;
  bit          started = 0;

  bit          m_active = 0;
  int          m_c0 = 0;
  int          m_fd = 0;
  draw_t       m_draws [$];
  bit          m_to = 0;
  bit          m_ov = 0;

  int          log_start_slot [$];
  int          log_start_cyc [$];
  logic [31:0] log_start_yx [$];
  int          log_abort_cyc [$];
  int          log_fd_cyc [$];

  bit          e_start, e_abort, e_in_draw;
  int          e_slot;
  logic [31:0] e_yx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_active || (cyc > m_fd);
  endfunction

  // Frame timeline: inactive visit costs 3 cycles, active visit 4 + draw wait.
  function automatic void plan_frame(input int c0);
    int    order [$];
    int    t;
    int    d;
    draw_t dr;
    for (int s = FIRST; s <= LAST; s++) if (s != PLAYER) order.push_back(s);
    order.push_back(PLAYER);
    m_draws.delete();
    t = c0 + 1;
    foreach (order[i]) begin
      if (mem[order[i]][31] == 1'b0) begin
        t += 3;
      end else begin
        d        = delay[order[i]];
        dr.slot  = order[i];
        dr.yx    = mem[order[i]];
        dr.st    = t + 2;
        if (d < 1 || d > TMO + 1) begin
          dr.en    = dr.st + TMO + 1;
          dr.abort = 1'b1;
        end else begin
          dr.en    = dr.st + d;
          dr.abort = 1'b0;
        end
        m_draws.push_back(dr);
        t = dr.en + 2;
      end
    end
    m_active = 1'b1;
    m_c0     = c0;
    m_fd     = t;
  endfunction

  // Synchronous table RAM: address sampled at the edge, data valid next cycle.
  initial begin
    logic [5:0] a;
    bus.table_data = '0;
    forever begin
      @(negedge clk);
      a = bus.table_addr;
      @(posedge clk);
      #1;
      bus.table_data = (^a === 1'bx) ? 32'h0 : mem[a];
    end
  end

  // Drawer: pulses done a per-slot delay after start (delay 0 = never).
  initial begin
    bus.obj_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.obj_done = (cyc == pend);
    end
  end

  // Per-cycle comparison, logging and model update.
  initial begin
    forever begin
      @(negedge clk);
      e_start = 0; e_abort = 0; e_in_draw = 0; e_slot = 0; e_yx = '0;
      foreach (m_draws[i]) begin
        if (m_draws[i].st == cyc) e_start = 1;
        if (m_draws[i].abort && m_draws[i].en == cyc) e_abort = 1;
        if (cyc >= m_draws[i].st && cyc <= m_draws[i].en) begin
          e_in_draw = 1;
          e_slot    = m_draws[i].slot;
          e_yx      = m_draws[i].yx;
        end
      end
      if (started) begin
        chk1("obj_start", bus.obj_start, e_start);
        chk1("obj_abort", bus.obj_abort, e_abort);
        chk1("frame_done", frame_done, m_active && cyc == m_fd);
        chk1("busy", busy, m_active && cyc > m_c0 && cyc <= m_fd);
        chk1("timeout_err", timeout_err, m_to);
        chk1("frame_overrun", frame_overrun, m_ov);
        if (e_in_draw) begin
          chk("obj_addr", 32'(bus.obj_addr), 32'(e_slot));
          chk("obj_Y_X", bus.obj_Y_X, e_yx);
        end
      end
      if (bus.obj_start === 1'b1) begin
        log_start_slot.push_back(int'(bus.obj_addr));
        log_start_cyc.push_back(cyc);
        log_start_yx.push_back(bus.obj_Y_X);
        pend = (delay[bus.obj_addr] == 0) ? -1 : cyc + delay[bus.obj_addr];
      end
      if (bus.obj_abort === 1'b1) log_abort_cyc.push_back(cyc);
      if (frame_done === 1'b1) log_fd_cyc.push_back(cyc);
      if (reset) begin
        m_active = 0; m_draws.delete(); m_to = 0; m_ov = 0;
      end else begin
        if (e_abort) m_to = 1;
        if (frame_start) begin
          if (m_active && cyc > m_c0 && cyc <= m_fd) m_ov = 1;
          else plan_frame(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic clear_logs();
    log_start_slot.delete(); log_start_cyc.delete(); log_start_yx.delete();
    log_abort_cyc.delete(); log_fd_cyc.delete();
  endtask

  task automatic fill_inactive();
    for (int i = 0; i < 64; i++) begin
      mem[i]   = $urandom & 32'h7FFF_FFFF;
      delay[i] = 5;
    end
  endtask

  task automatic wait_end(input string nm, input int lim);
    int n = 0;
    while (!(m_idle() && busy === 1'b0) && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s frame not finished within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    int c0;
    int n;
    fill_inactive();
    reset = 1'b1;
    tick();
    started = 1;
    tick();
    reset = 1'b0;
    tick();

    // All slots inactive: no draws, frame_done 124 cycles after frame_start.
    clear_logs();
    c0 = cyc;
    pulse_frame();
    wait_end("t1", 400);
    chk("t1_fd_count", log_fd_cyc.size(), 1);
    if (log_fd_cyc.size() > 0) chk("t1_fd_latency", log_fd_cyc[0] - c0, 124);
    chk("t1_no_start", log_start_slot.size(), 0);

    // Slots 5 and player active, drawer answers after 6 cycles.
    fill_inactive();
    for (int i = 0; i < 64; i++) delay[i] = 6;
    mem[5]  = 32'h8050_0010;
    mem[32] = 32'h8123_4567;
    clear_logs();
    pulse_frame();
    wait_end("t2", 400);
    chk("t2_start_count", log_start_slot.size(), 2);
    if (log_start_slot.size() == 2) begin
      chk("t2_first_slot", log_start_slot[0], 5);
      chk("t2_last_slot", log_start_slot[1], 32);
      chk("t2_yx5", log_start_yx[0], 32'h8050_0010);
    end

    // Hung draw on slot 10: abort 4096 cycles after start, pass continues.
    fill_inactive();
    mem[10] = 32'h8000_00AA; delay[10] = 0;
    mem[11] = 32'h8000_00BB; delay[11] = 3;
    clear_logs();
    pulse_frame();
    wait_end("t3", 6000);
    chk("t3_abort_count", log_abort_cyc.size(), 1);
    if (log_abort_cyc.size() == 1 && log_start_cyc.size() > 0)
      chk("t3_abort_latency", log_abort_cyc[0] - log_start_cyc[0], 4096);
    chk1("t3_timeout_err", timeout_err, 1'b1);
    chk("t3_start_count", log_start_slot.size(), 2);
    if (log_start_slot.size() == 2) chk("t3_next_slot", log_start_slot[1], 11);
    chk("t3_fd_count", log_fd_cyc.size(), 1);

    // Re-pulse mid-pass at slot 20: overrun flagged, pass unaffected.
    fill_inactive();
    mem[25] = 32'h8000_0025; delay[25] = 4;
    clear_logs();
    pulse_frame();
    n = 0;
    while (bus.table_addr !== 6'd20 && n < 200) begin tick(); n++; end
    chk1("t4_reach_slot20", n < 200, 1'b1);
    pulse_frame();
    wait_end("t4", 400);
    chk1("t4_overrun", frame_overrun, 1'b1);
    chk("t4_fd_count", log_fd_cyc.size(), 1);
    chk("t4_start_count", log_start_slot.size(), 1);
    clear_logs();
    pulse_frame();
    wait_end("t4b", 400);
    chk("t4b_fd_count", log_fd_cyc.size(), 1);
    chk("t4b_start_count", log_start_slot.size(), 1);

    // Reset during the draw of slot 15; late done ignored; restart from slot 2.
    fill_inactive();
    mem[2]  = 32'h8000_0002; delay[2] = 3;
    mem[15] = 32'h8000_0015; delay[15] = 40;
    clear_logs();
    pulse_frame();
    n = 0;
    while (!(bus.obj_start === 1'b1 && bus.obj_addr === 6'd15) && n < 500) begin tick(); n++; end
    chk1("t5_reach_slot15", n < 500, 1'b1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("t5_rst_start", bus.obj_start, 1'b0);
    chk1("t5_rst_abort", bus.obj_abort, 1'b0);
    chk1("t5_rst_fd", frame_done, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_addr", 32'(bus.obj_addr), 32'd0);
    chk("t5_rst_yx", bus.obj_Y_X, 32'd0);
    chk("t5_rst_taddr", 32'(bus.table_addr), 32'd0);
    chk1("t5_rst_to", timeout_err, 1'b0);
    chk1("t5_rst_ov", frame_overrun, 1'b0);
    repeat (60) tick();
    clear_logs();
    pulse_frame();
    wait_end("t5", 600);
    chk1("t5_has_start", log_start_slot.size() > 0, 1'b1);
    if (log_start_slot.size() > 0) chk("t5_restart_slot", log_start_slot[0], 2);

    // Done arrives on the watchdog limit cycle: no abort. Then pulse with frame_done.
    fill_inactive();
    mem[7] = 32'h8000_0007; delay[7] = 4096;
    clear_logs();
    pulse_frame();
    n = 0;
    while (frame_done !== 1'b1 && n < 6000) begin tick(); n++; end
    chk1("t6_reach_fd", n < 6000, 1'b1);
    pulse_frame();
    repeat (5) tick();
    chk("t6_abort_count", log_abort_cyc.size(), 0);
    chk1("t6_timeout_err", timeout_err, 1'b0);
    chk("t6_start_count", log_start_slot.size(), 1);
    chk1("t6_overrun", frame_overrun, 1'b1);
    chk1("t6_idle_busy", busy, 1'b0);

    // Randomized frames with occasional mid-pass overruns.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]   = $urandom;
        if ($urandom_range(2, 0) != 0) mem[i][31] = 1'b0;
        delay[i] = $urandom_range(12, 1);
      end
      pulse_frame();
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(100, 1)) tick();
        if (!m_idle()) pulse_frame();
      end
      wait_end("rand", 2000);
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
